// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: multiplexes one pad-side IO group across NUM_DESIGNS user
// designs daisy-chained on a serial scan chain of L = NUM_DESIGNS*IO_W bits.
// Each frame shifts the pad inputs into the selected slot, pulses a latch
// enable, captures every design's outputs, then shifts the chain back and
// updates the pad outputs from the selected slot.
//
// Ports:
//   wb_clk_i        system clock, rising edge
//   wb_rst_ni       asynchronous active-low reset
//   enable_i        run frames continuously while high
//   sel_i           design slot, sampled at frame start
//   div_i           phase length minus one, sampled at frame start
//   io_in           pad inputs, sampled at frame start
//   io_out          pad outputs, updated only when a frame completes
//   scan_clk_o      chain shift/capture clock
//   scan_data_o     serial data into the chain
//   scan_data_i     serial data from the chain end
//   scan_select_o   chain captures design outputs on scan_clk rise
//   scan_latch_en_o designs latch chain contents into their inputs
//   busy_o          high from frame start through the done cycle
//   frame_done_o    one-cycle pulse when io_out updates
//   sel_err_o       pulses with frame_done_o when sel >= NUM_DESIGNS
module scan_chain_ctrl #(
  parameter int IO_W        = 8,
  parameter int NUM_DESIGNS = 4,
  parameter int DIV_W       = 8,
  parameter int SEL_W       = (NUM_DESIGNS > 1) ? $clog2(NUM_DESIGNS) : 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             enable_i,
  input  logic [SEL_W-1:0] sel_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [IO_W-1:0]  io_in,
  output logic [IO_W-1:0]  io_out,
  output logic             scan_clk_o,
  output logic             scan_data_o,
  input  logic             scan_data_i,
  output logic             scan_select_o,
  output logic             scan_latch_en_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             sel_err_o
);

  localparam int unsigned L  = NUM_DESIGNS * IO_W;
  localparam int unsigned BW = $clog2(L + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_LATCH,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic             sel_ok_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] ph_q;
  logic [BW-1:0]    bit_q;
  logic             hi_q;
  // Bits still to be sent after the current one; MSB is the next bit out.
  logic [L-2:0]     sh_q;
  logic [L-1:0]     r_q;

  logic [IO_W-1:0]  io_out_q;
  logic             scan_clk_q;
  logic             scan_data_q;
  logic             scan_select_q;
  logic             latch_en_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             sel_err_q;

  logic [L-1:0]     vec_d;
  logic [L-1:0]     r_d;
  logic [IO_W-1:0]  slot_d;
  logic             sel_ok_d;
  logic             sample_en;
  logic             phase_end;
  logic             last_bit;
  logic             start_frame;

  assign phase_end   = (ph_q == div_q);
  assign last_bit    = (bit_q == BW'(L - 1));
  assign start_frame = ((state_q == S_IDLE) || (state_q == S_DONE)) && enable_i;
  assign sample_en   = (state_q == S_SHIFT_OUT) && hi_q && (ph_q == '0);
  assign sel_ok_d    = (32'(sel_i) < 32'(NUM_DESIGNS));

  // r_d folds in the sample taken this cycle, so with 1-cycle phases the last
  // bit still reaches io_out on the transition into DONE.
  always_comb begin
    vec_d  = '0;
    slot_d = '0;
    r_d    = sample_en ? {r_q[L-2:0], scan_data_i} : r_q;
    for (int unsigned i = 0; i < NUM_DESIGNS; i++) begin
      if (sel_i == SEL_W'(i)) vec_d[i*IO_W +: IO_W] = io_in;
      if (sel_q == SEL_W'(i)) slot_d = r_d[i*IO_W +: IO_W];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      sel_ok_q      <= 1'b0;
      div_q         <= '0;
      ph_q          <= '0;
      bit_q         <= '0;
      hi_q          <= 1'b0;
      sh_q          <= '0;
      r_q           <= '0;
      io_out_q      <= '0;
      scan_clk_q    <= 1'b0;
      scan_data_q   <= 1'b0;
      scan_select_q <= 1'b0;
      latch_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      ph_q <= phase_end ? '0 : ph_q + 1'b1;
      r_q  <= r_d;

      case (state_q)
        S_IDLE: begin
          ph_q <= '0;
        end

        S_SHIFT_IN: begin
          if (phase_end) begin
            if (!hi_q) begin
              hi_q       <= 1'b1;
              scan_clk_q <= 1'b1;
            end else begin
              hi_q       <= 1'b0;
              scan_clk_q <= 1'b0;
              if (last_bit) begin
                bit_q       <= '0;
                scan_data_q <= 1'b0;
                latch_en_q  <= 1'b1;
                state_q     <= S_LATCH;
              end else begin
                bit_q       <= bit_q + 1'b1;
                scan_data_q <= sh_q[L-2];
                sh_q        <= {sh_q[L-3:0], 1'b0};
              end
            end
          end
        end

        S_LATCH: begin
          if (phase_end) begin
            latch_en_q    <= 1'b0;
            scan_select_q <= 1'b1;
            state_q       <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (phase_end) begin
            if (!hi_q) begin
              hi_q       <= 1'b1;
              scan_clk_q <= 1'b1;
            end else begin
              hi_q          <= 1'b0;
              scan_clk_q    <= 1'b0;
              scan_select_q <= 1'b0;
              state_q       <= S_SHIFT_OUT;
            end
          end
        end

        S_SHIFT_OUT: begin
          if (phase_end) begin
            if (!hi_q) begin
              hi_q       <= 1'b1;
              scan_clk_q <= 1'b1;
            end else begin
              hi_q       <= 1'b0;
              scan_clk_q <= 1'b0;
              if (last_bit) begin
                bit_q        <= '0;
                frame_done_q <= 1'b1;
                sel_err_q    <= !sel_ok_q;
                if (sel_ok_q) io_out_q <= slot_d;
                state_q      <= S_DONE;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          frame_done_q <= 1'b0;
          sel_err_q    <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase

      // DONE doubles as the start cycle of the next frame when enable_i is
      // still high, so back-to-back frames leave no idle gap.
      if (start_frame) begin
        sel_q       <= sel_i;
        sel_ok_q    <= sel_ok_d;
        div_q       <= div_i;
        sh_q        <= vec_d[L-2:0];
        scan_data_q <= vec_d[L-1];
        scan_clk_q  <= 1'b0;
        hi_q        <= 1'b0;
        bit_q       <= '0;
        ph_q        <= '0;
        busy_q      <= 1'b1;
        state_q     <= S_SHIFT_IN;
      end
    end
  end

  assign io_out          = io_out_q;
  assign scan_clk_o      = scan_clk_q;
  assign scan_data_o     = scan_data_q;
  assign scan_select_o   = scan_select_q;
  assign scan_latch_en_o = latch_en_q;
  assign busy_o          = busy_q;
  assign frame_done_o    = frame_done_q;
  assign sel_err_o       = sel_err_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Testbench for scan_chain_ctrl: a 4-slot instance and a 3-slot instance, each
// attached to a behavioural chain of user designs (design output = latched
// input XOR a per-slot key). Expected chain contents at latch time and expected
// io_out/sel_err at frame_done are queued when a frame is started.
module tb_scan_chain_ctrl;

  localparam logic [31:0] KEY4 = 32'h1E99C35A;
  localparam logic [23:0] KEY3 = 24'h6BD427;

  typedef struct packed {
    logic [7:0] out;
    logic       err;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] key4v = KEY4;
  logic [23:0] key3v = KEY3;

  // 4-slot instance
  logic       en4 = 1'b0;
  logic [1:0] sel4 = '0;
  logic [7:0] div4 = '0, in4 = '0, out4;
  logic       sclk4, sdo4, ssel4, slat4, busy4, done4, err4;
  logic       sdi4 = 1'b0;

  // 3-slot instance
  logic       en3 = 1'b0;
  logic [1:0] sel3 = '0;
  logic [7:0] div3 = '0, in3 = '0, out3;
  logic       sclk3, sdo3, ssel3, slat3, busy3, done3, err3;
  logic       sdi3 = 1'b0;

  scan_chain_ctrl #(.IO_W(8), .NUM_DESIGNS(4), .DIV_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(en4), .sel_i(sel4),
    .div_i(div4), .io_in(in4), .io_out(out4), .scan_clk_o(sclk4),
    .scan_data_o(sdo4), .scan_data_i(sdi4), .scan_select_o(ssel4),
    .scan_latch_en_o(slat4), .busy_o(busy4), .frame_done_o(done4),
    .sel_err_o(err4)
  );

  scan_chain_ctrl #(.IO_W(8), .NUM_DESIGNS(3), .DIV_W(8)) dut3 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_i(en3), .sel_i(sel3),
    .div_i(div3), .io_in(in3), .io_out(out3), .scan_clk_o(sclk3),
    .scan_data_o(sdo3), .scan_data_i(sdi3), .scan_select_o(ssel3),
    .scan_latch_en_o(slat3), .busy_o(busy3), .frame_done_o(done3),
    .sel_err_o(err3)
  );

  // Chain models: shift/capture on scan_clk rise, chain end seen through a
  // lockup stage that updates on scan_clk fall.
  logic [31:0] ch4 = '0, lat4 = '0;
  logic [23:0] ch3 = '0, lat3 = '0;
  always @(posedge sclk4) ch4 <= ssel4 ? (lat4 ^ KEY4) : {ch4[30:0], sdo4};
  always @(negedge sclk4) sdi4 <= ch4[31];
  always @(posedge slat4) lat4 <= ch4;
  always @(posedge sclk3) ch3 <= ssel3 ? (lat3 ^ KEY3) : {ch3[22:0], sdo3};
  always @(negedge sclk3) sdi3 <= ch3[23];
  always @(posedge slat3) lat3 <= ch3;

  // Scoreboards
  logic [31:0] q_v4[$];
  logic [23:0] q_v3[$];
  res_t        q_r4[$];
  res_t        q_r3[$];
  logic        slat4_p = 1'b0, slat3_p = 1'b0;

  always @(negedge clk) begin : mon
    res_t        r;
    logic [31:0] v4;
    logic [23:0] v3;
    if (rst_n) begin
      if (slat4 && !slat4_p) begin
        n_tests++;
        if (q_v4.size() == 0) begin
          n_fail++;
          $display("FAIL latch4_unexpected: chain=%h, no frame expected", ch4);
        end else begin
          v4 = q_v4.pop_front();
          if (ch4 !== v4) begin
            n_fail++;
            $display("FAIL latch4_chain: got %h expected %h", ch4, v4);
          end
        end
      end
      if (slat3 && !slat3_p) begin
        n_tests++;
        if (q_v3.size() == 0) begin
          n_fail++;
          $display("FAIL latch3_unexpected: chain=%h, no frame expected", ch3);
        end else begin
          v3 = q_v3.pop_front();
          if (ch3 !== v3) begin
            n_fail++;
            $display("FAIL latch3_chain: got %h expected %h", ch3, v3);
          end
        end
      end
      if (done4) begin
        n_tests++;
        if (q_r4.size() == 0) begin
          n_fail++;
          $display("FAIL done4_unexpected: io_out=%h, no frame expected", out4);
        end else begin
          r = q_r4.pop_front();
          if (out4 !== r.out || err4 !== r.err) begin
            n_fail++;
            $display("FAIL done4_result: got out=%h err=%b expected out=%h err=%b",
                     out4, err4, r.out, r.err);
          end
        end
      end
      if (done3) begin
        n_tests++;
        if (q_r3.size() == 0) begin
          n_fail++;
          $display("FAIL done3_unexpected: io_out=%h, no frame expected", out3);
        end else begin
          r = q_r3.pop_front();
          if (out3 !== r.out || err3 !== r.err) begin
            n_fail++;
            $display("FAIL done3_result: got out=%h err=%b expected out=%h err=%b",
                     out3, err3, r.out, r.err);
          end
        end
      end
    end
    slat4_p <= slat4;
    slat3_p <= slat3;
  end

  function automatic logic [31:0] mkv4(input logic [1:0] s, input logic [7:0] d);
    logic [31:0] v;
    v = '0;
    v[s*8 +: 8] = d;
    return v;
  endfunction

  function automatic logic [23:0] mkv3(input logic [1:0] s, input logic [7:0] d);
    logic [23:0] v;
    v = '0;
    if (s < 2'd3) v[s*8 +: 8] = d;
    return v;
  endfunction

  // Starts a frame on the 4-slot instance and queues its expectations;
  // returns the cycle count of the first SHIFT_IN cycle.
  task automatic start4(input logic [1:0] s, input logic [7:0] d,
                        input logic [7:0] din, output int start);
    res_t r;
    @(negedge clk);
    sel4 = s; div4 = d; in4 = din; en4 = 1'b1;
    r.out = din ^ key4v[s*8 +: 8];
    r.err = 1'b0;
    q_v4.push_back(mkv4(s, din));
    q_r4.push_back(r);
    @(negedge clk);
    start = cyc;
  endtask

  task automatic start3(input logic [1:0] s, input logic [7:0] din,
                        input logic [7:0] prev_out, output int start);
    res_t r;
    @(negedge clk);
    sel3 = s; div3 = '0; in3 = din; en3 = 1'b1;
    r.err = (s == 2'd3);
    r.out = r.err ? prev_out : (din ^ key3v[s*8 +: 8]);
    q_v3.push_back(mkv3(s, din));
    q_r3.push_back(r);
    @(negedge clk);
    start = cyc;
  endtask

  task automatic wait_done(input bit which3, input int budget,
                           output int at, output bit timed_out);
    timed_out = 1'b1;
    at = 0;
    for (int i = 0; i < budget; i++) begin
      if (which3 ? done3 : done4) begin
        at = cyc;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({out4, sclk4, sdo4, ssel4, slat4, busy4, done4, err4} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset4_outputs: got %h expected 0",
               {out4, sclk4, sdo4, ssel4, slat4, busy4, done4, err4});
    end
    n_tests++;
    if ({out3, sclk3, sdo3, ssel3, slat3, busy3, done3, err3} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset3_outputs: got %h expected 0",
               {out3, sclk3, sdo3, ssel3, slat3, busy3, done3, err3});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (busy4 !== 1'b0 || sclk4 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_frame: got busy4=%b sclk4=%b busy3=%b expected 0 0 0",
               busy4, sclk4, busy3);
    end
  endtask

  task automatic test_single_frame;
    int start, at;
    bit to;
    start4(2'd2, 8'd0, 8'hA5, start);
    en4 = 1'b0;
    wait_done(1'b0, 400, at, to);
    n_tests++;
    if (to || (at - start) != 131) begin
      n_fail++;
      $display("FAIL single_len: got timeout=%b cycles=%0d expected 131", to, at - start);
    end
    n_tests++;
    if (out4 !== 8'h3C || busy4 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_out: got io_out=%h busy=%b expected 3c 1", out4, busy4);
    end
    @(negedge clk);
    n_tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b done=%b expected 0 0", busy4, done4);
    end
  endtask

  task automatic test_divider;
    int start, rises, bad, latw, hirun;
    bit done, prev;
    start4(2'd0, 8'd3, 8'h5A, start);
    en4 = 1'b0;
    rises = 0; bad = 0; latw = 0; hirun = 0; done = 1'b0; prev = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (sclk4) begin
        if (!prev) rises++;
        hirun++;
      end else if (prev) begin
        if (hirun != 4) bad++;
        hirun = 0;
      end
      if (slat4) latw++;
      prev = sclk4;
      if (done4) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!done || (cyc - start) != 524) begin
      n_fail++;
      $display("FAIL div_len: got done=%b cycles=%0d expected 524", done, cyc - start);
    end
    n_tests++;
    if (rises != 65 || bad != 0) begin
      n_fail++;
      $display("FAIL div_clk: got rises=%0d bad_high=%0d expected 65 0", rises, bad);
    end
    n_tests++;
    if (latw != 4) begin
      n_fail++;
      $display("FAIL div_latch_width: got %0d expected 4", latw);
    end
    n_tests++;
    if (out4 !== 8'h00) begin
      n_fail++;
      $display("FAIL div_out: got %h expected 00", out4);
    end
  endtask

  task automatic test_back_to_back;
    int start, t1, t2, nd, bz;
    res_t r;
    start4(2'd1, 8'd0, 8'h11, start);
    nd = 0; bz = 0; t1 = 0; t2 = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 20) begin
        in4 = 8'h22;
        r.out = 8'h22 ^ 8'hC3;
        r.err = 1'b0;
        q_v4.push_back(mkv4(2'd1, 8'h22));
        q_r4.push_back(r);
      end
      if (!busy4) bz++;
      if (done4) begin
        nd++;
        if (nd == 1) t1 = cyc;
        else begin
          t2 = cyc;
          en4 = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (nd != 2 || (t1 - start) != 131 || (t2 - t1) != 132) begin
      n_fail++;
      $display("FAIL b2b_timing: got dones=%0d first=%0d spacing=%0d expected 2 131 132",
               nd, t1 - start, t2 - t1);
    end
    n_tests++;
    if (bz != 0) begin
      n_fail++;
      $display("FAIL b2b_busy: got %0d idle cycles expected 0", bz);
    end
    n_tests++;
    if (out4 !== 8'hE1) begin
      n_fail++;
      $display("FAIL b2b_out: got %h expected e1", out4);
    end
    @(negedge clk);
  endtask

  task automatic test_invalid_sel;
    int start, at;
    bit to;
    start3(2'd1, 8'h77, 8'h00, start);
    en3 = 1'b0;
    wait_done(1'b1, 300, at, to);
    n_tests++;
    if (to || (at - start) != 99 || out3 !== 8'hA3 || err3 !== 1'b0) begin
      n_fail++;
      $display("FAIL sel3_valid: got timeout=%b cycles=%0d out=%h err=%b expected 0 99 a3 0",
               to, at - start, out3, err3);
    end
    start3(2'd3, 8'hEE, 8'hA3, start);
    en3 = 1'b0;
    wait_done(1'b1, 300, at, to);
    n_tests++;
    if (to || err3 !== 1'b1 || done3 !== 1'b1 || out3 !== 8'hA3) begin
      n_fail++;
      $display("FAIL sel3_invalid: got timeout=%b err=%b done=%b out=%h expected 0 1 1 a3",
               to, err3, done3, out3);
    end
    @(negedge clk);
    n_tests++;
    if (err3 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL sel3_err_pulse: got err=%b busy=%b expected 0 0", err3, busy3);
    end
  endtask

  task automatic test_midframe_inputs;
    int start, at, bz;
    bit to;
    start4(2'd3, 8'd1, 8'hC6, start);
    repeat (10) @(negedge clk);
    en4 = 1'b0; sel4 = 2'd0; div4 = 8'd0; in4 = 8'h00;
    wait_done(1'b0, 600, at, to);
    n_tests++;
    if (to || (at - start) != 262 || out4 !== 8'hD8) begin
      n_fail++;
      $display("FAIL mid_frame: got timeout=%b cycles=%0d out=%h expected 0 262 d8",
               to, at - start, out4);
    end
    bz = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy4) bz++;
    end
    n_tests++;
    if (bz != 20) begin
      n_fail++;
      $display("FAIL mid_idle: got %0d idle cycles expected 20", bz);
    end
  endtask

  task automatic test_reset_midframe;
    int start;
    start4(2'd1, 8'd0, 8'h3F, start);
    repeat (80) @(negedge clk);
    n_tests++;
    if (busy4 !== 1'b1 || ssel4 !== 1'b0 || slat4 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pre: got busy=%b sel=%b lat=%b expected 1 0 0", busy4, ssel4, slat4);
    end
    rst_n = 1'b0;
    en4 = 1'b0;
    q_v4.delete();
    q_r4.delete();
    #1;
    n_tests++;
    if ({out4, sclk4, sdo4, ssel4, slat4, busy4, done4, err4} !== 15'd0) begin
      n_fail++;
      $display("FAIL rst_async: got %h expected 0",
               {out4, sclk4, sdo4, ssel4, slat4, busy4, done4, err4});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if (busy4 !== 1'b0 || out4 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_after: got busy=%b out=%h expected 0 00", busy4, out4);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_divider;
    test_back_to_back;
    test_invalid_sel;
    test_midframe_inputs;
    test_reset_midframe;
    n_tests++;
    if (q_r4.size() != 0 || q_r3.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d/%0d pending results expected 0/0",
               q_r4.size(), q_r3.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
